// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM that walks each RV32I instruction through
// fetch/decode/execute/memory/writeback and drives the datapath selects and
// strobes. Memory states stall on mem_ready, bounded by a wait counter.
// Optional feature macro: MCCTRL_JAL_EN (adds the JUMP state for opcode 1101111).
module multicycle_controller #(
  parameter int WAIT_MAX = 15,
  parameter int OPCODE_W = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                mem_ready,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCSrc,
  output logic                AdrSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                MemtoReg,
  output logic                Branch,
  output logic                instr_done,
  output logic                trap
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_MAX - 1);

  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_ITYPE = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_BRNCH = OPCODE_W'(7'b1100011);
`ifdef MCCTRL_JAL_EN
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(7'b1101111);
`endif

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC_R = 4'd7,
    EXEC_I = 4'd8,
    ALUWB  = 4'd9,
    BRANCH = 4'd10,
`ifdef MCCTRL_JAL_EN
    JUMP   = 4'd11,
`endif
    TRAP   = 4'd12
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             in_mem_state;
  logic             timeout;

  // A memory state is one that stalls on the mem_ready handshake.
  assign in_mem_state = (state_reg == FETCH) || (state_reg == MEMRD) || (state_reg == MEMWR);
  // The current stalled cycle is the WAIT_MAX-th consecutive one.
  assign timeout      = in_mem_state && !mem_ready && (wait_cnt_reg == LAST_WAIT);

  // State and wait counter registers; reset returns straight to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Counter only runs while a memory state stalls; any completion or other
  // state leaves it at zero, so each memory state starts from a clean count.
  always_comb begin
    wait_cnt_next = '0;
    if (in_mem_state && !mem_ready && !timeout)
      wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  // Next-state logic and Moore outputs (IRWrite/PCWrite in FETCH and
  // instr_done in MEMWR are qualified by mem_ready).
  always_comb begin
    state_next = state_reg;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    Branch     = 1'b0;
    instr_done = 1'b0;
    trap       = 1'b0;
    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b10;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready)    state_next = DECODE;
        else if (timeout) state_next = TRAP;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Opcode)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXEC_R;
          OP_ITYPE:          state_next = EXEC_I;
          OP_BRNCH:          state_next = BRANCH;
`ifdef MCCTRL_JAL_EN
          OP_JAL:            state_next = JUMP;
`endif
          default:           state_next = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (Opcode == OP_LOAD) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready)    state_next = MEMWB;
        else if (timeout) state_next = TRAP;
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        AdrSrc     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready)    state_next = FETCH;
        else if (timeout) state_next = TRAP;
      end
      EXEC_R: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      EXEC_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        Branch     = 1'b1;
        PCSrc      = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
`ifdef MCCTRL_JAL_EN
      JUMP: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        PCSrc      = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
`endif
      TRAP: trap = 1'b1;
      default: state_next = TRAP;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (instantiated with WAIT_MAX=4).
// Each step drives Opcode/mem_ready at the falling edge, then compares the
// full output vector against a hand-written expectation for that cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       IRWrite, PCWrite, PCSrc, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
  logic       MemRead, MemWrite, RegWrite, MemtoReg, Branch, instr_done, trap;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  always #5 clk = ~clk;

  multicycle_controller #(.WAIT_MAX(4), .OPCODE_W(7)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .Branch(Branch), .instr_done(instr_done), .trap(trap)
  );

  function automatic logic [16:0] pk(input logic irw, pcw, pcs, adr,
                                     input logic [1:0] sa, sb, op,
                                     input logic mr, mw, rw, m2r, br, dn, tr);
    return {irw, pcw, pcs, adr, sa, sb, op, mr, mw, rw, m2r, br, dn, tr};
  endfunction

  logic [16:0] E_ZERO, E_FETCH_R, E_FETCH_W, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB;
  logic [16:0] E_MEMWR_W, E_MEMWR_R, E_EXECR, E_EXECI, E_ALUWB, E_BRANCH, E_JUMP, E_TRAP;

  // Drive inputs, let them settle, compare, then move to the next falling edge.
  task automatic step(input string tag, input logic [6:0] op, input logic rdy,
                      input logic [16:0] exp);
    logic [16:0] obs;
    Opcode    = op;
    mem_ready = rdy;
    #1;
    obs = {IRWrite, PCWrite, PCSrc, AdrSrc, ALUSrcA, ALUSrcB, ALUOp,
           MemRead, MemWrite, RegWrite, MemtoReg, Branch, instr_done, trap};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
    $display("vec %0d %s op=%b rdy=%b out=%05h", vectors, tag, op, rdy, obs);
    @(negedge clk);
  endtask

  // Synchronously-aligned reset pulse, released on a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    step("reset_held", 7'd0, 1'b1, E_ZERO);
    reset = 1'b0;
  endtask

  initial begin
    E_ZERO    = '0;
    E_FETCH_R = pk(1,1,0,0,2'b00,2'b10,2'b00,1,0,0,0,0,0,0);
    E_FETCH_W = pk(0,0,0,0,2'b00,2'b10,2'b00,1,0,0,0,0,0,0);
    E_DECODE  = pk(0,0,0,0,2'b01,2'b01,2'b00,0,0,0,0,0,0,0);
    E_MEMADR  = pk(0,0,0,0,2'b10,2'b01,2'b00,0,0,0,0,0,0,0);
    E_MEMRD   = pk(0,0,0,1,2'b00,2'b00,2'b00,1,0,0,0,0,0,0);
    E_MEMWB   = pk(0,0,0,0,2'b00,2'b00,2'b00,0,0,1,1,0,1,0);
    E_MEMWR_W = pk(0,0,0,1,2'b00,2'b00,2'b00,0,1,0,0,0,0,0);
    E_MEMWR_R = pk(0,0,0,1,2'b00,2'b00,2'b00,0,1,0,0,0,1,0);
    E_EXECR   = pk(0,0,0,0,2'b10,2'b00,2'b10,0,0,0,0,0,0,0);
    E_EXECI   = pk(0,0,0,0,2'b10,2'b01,2'b10,0,0,0,0,0,0,0);
    E_ALUWB   = pk(0,0,0,0,2'b00,2'b00,2'b00,0,0,1,0,0,1,0);
    E_BRANCH  = pk(0,0,1,0,2'b10,2'b00,2'b01,0,0,0,0,1,1,0);
    E_JUMP    = pk(0,1,1,0,2'b01,2'b10,2'b00,0,0,1,0,0,1,0);
    E_TRAP    = pk(0,0,0,0,2'b00,2'b00,2'b00,0,0,0,0,0,0,1);

    @(negedge clk);
    do_reset();
    step("idle", 7'd0, 1'b1, E_ZERO);

    // R-type: 4 cycles, retire on the 4th
    step("r_fetch",  RT, 1'b1, E_FETCH_R);
    step("r_decode", RT, 1'b1, E_DECODE);
    step("r_exec",   RT, 1'b1, E_EXECR);
    step("r_aluwb",  RT, 1'b1, E_ALUWB);

    // I-type
    step("i_fetch",  IT, 1'b1, E_FETCH_R);
    step("i_decode", IT, 1'b1, E_DECODE);
    step("i_exec",   IT, 1'b1, E_EXECI);
    step("i_aluwb",  IT, 1'b1, E_ALUWB);

    // LW with 3 stalls in MEMRD: 8 cycles; 4th MEMRD cycle completes right
    // when the counter would hit WAIT_MAX, so completion wins.
    step("lw_fetch",  LW, 1'b1, E_FETCH_R);
    step("lw_decode", LW, 1'b1, E_DECODE);
    step("lw_memadr", LW, 1'b1, E_MEMADR);
    step("lw_memrd0", LW, 1'b0, E_MEMRD);
    step("lw_memrd1", LW, 1'b0, E_MEMRD);
    step("lw_memrd2", LW, 1'b0, E_MEMRD);
    step("lw_memrd3", LW, 1'b1, E_MEMRD);
    step("lw_memwb",  LW, 1'b1, E_MEMWB);

    // SW with 3 stalls in FETCH and 3 in MEMWR: counter must clear between.
    step("sw_fetchw0", SW, 1'b0, E_FETCH_W);
    step("sw_fetchw1", SW, 1'b0, E_FETCH_W);
    step("sw_fetchw2", SW, 1'b0, E_FETCH_W);
    step("sw_fetch",   SW, 1'b1, E_FETCH_R);
    step("sw_decode",  SW, 1'b1, E_DECODE);
    step("sw_memadr",  SW, 1'b1, E_MEMADR);
    step("sw_memwr0",  SW, 1'b0, E_MEMWR_W);
    step("sw_memwr1",  SW, 1'b0, E_MEMWR_W);
    step("sw_memwr2",  SW, 1'b0, E_MEMWR_W);
    step("sw_memwr3",  SW, 1'b1, E_MEMWR_R);

    // BEQ: 3 cycles
    step("beq_fetch",  BQ, 1'b1, E_FETCH_R);
    step("beq_decode", BQ, 1'b1, E_DECODE);
    step("beq_branch", BQ, 1'b1, E_BRANCH);

    // JAL: JUMP when enabled, otherwise illegal
    step("jal_fetch",  JL, 1'b1, E_FETCH_R);
    step("jal_decode", JL, 1'b1, E_DECODE);
`ifdef MCCTRL_JAL_EN
    step("jal_jump",   JL, 1'b1, E_JUMP);
    step("jal_next",   RT, 1'b1, E_FETCH_R);
`else
    step("jal_trap",   JL, 1'b1, E_TRAP);
    step("jal_trap2",  RT, 1'b1, E_TRAP);
`endif

    // Illegal opcode traps after DECODE and stays trapped
    do_reset();
    step("bad_idle",   BAD, 1'b1, E_ZERO);
    step("bad_fetch",  BAD, 1'b1, E_FETCH_R);
    step("bad_decode", BAD, 1'b1, E_DECODE);
    step("bad_trap0",  BAD, 1'b1, E_TRAP);
    step("bad_trap1",  RT,  1'b0, E_TRAP);

    // FETCH timeout: trap after the 4th stalled cycle, sticky
    do_reset();
    step("to_idle",   RT, 1'b0, E_ZERO);
    step("to_fetch0", RT, 1'b0, E_FETCH_W);
    step("to_fetch1", RT, 1'b0, E_FETCH_W);
    step("to_fetch2", RT, 1'b0, E_FETCH_W);
    step("to_fetch3", RT, 1'b0, E_FETCH_W);
    step("to_trap0",  RT, 1'b1, E_TRAP);
    step("to_trap1",  RT, 1'b1, E_TRAP);

    // MEMRD timeout after 4 stalls
    do_reset();
    step("mt_idle",   LW, 1'b1, E_ZERO);
    step("mt_fetch",  LW, 1'b1, E_FETCH_R);
    step("mt_decode", LW, 1'b1, E_DECODE);
    step("mt_memadr", LW, 1'b1, E_MEMADR);
    step("mt_memrd0", LW, 1'b0, E_MEMRD);
    step("mt_memrd1", LW, 1'b0, E_MEMRD);
    step("mt_memrd2", LW, 1'b0, E_MEMRD);
    step("mt_memrd3", LW, 1'b0, E_MEMRD);
    step("mt_trap",   LW, 1'b1, E_TRAP);

    // Asynchronous reset mid-MEMRD clears outputs at once
    do_reset();
    step("ar_idle",   LW, 1'b1, E_ZERO);
    step("ar_fetch",  LW, 1'b1, E_FETCH_R);
    step("ar_decode", LW, 1'b1, E_DECODE);
    step("ar_memadr", LW, 1'b1, E_MEMADR);
    mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    step("ar_async",  LW, 1'b0, E_ZERO);
    reset = 1'b0;
    step("ar_rel_idle",  LW, 1'b1, E_ZERO);
    step("ar_rel_fetch", LW, 1'b1, E_FETCH_R);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "bench time limit");
  end

endmodule
